vram_bus_arbiter: RTL
=====================

Name: vram_bus_arbiter

Overview:
- Single-port arbiter and sequencer that shares one word-wide RAM port between three requesters: video scan-out fetch, the disk copy engine (DMA) and the CPU bus.
- Sits between the CPU/disk/video blocks and the memory array in the clk_sys domain.
- Grants one transaction at a time, drives fixed-latency memory strobes, and returns data with a one-cycle ack per requester.
- Video has fixed top priority. DMA has priority over the CPU, bounded by an anti-starvation counter.

Parameters:
AW, 24, word address width
DW, 16, data width (byte enables are DW/8 bits)
MEM_LAT, 2, cycles from the mem_rd strobe to valid mem_dout (range 1..7)
CPU_STARVE, 8, consecutive DMA grants allowed while cpu_req is pending before the CPU is forced

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
vid_req  in  1  video read request (level)
vid_addr  in  AW  video word address
vid_dout  out  DW  video read data
vid_ack  out  1  video completion pulse
dma_req  in  1  disk copy request (level)
dma_we  in  1  1 = write, 0 = read
dma_addr  in  AW  DMA word address
dma_din  in  DW  DMA write data
dma_dout  out  DW  DMA read data
dma_ack  out  1  DMA completion pulse
cpu_req  in  1  CPU request (level)
cpu_we  in  1  1 = write, 0 = read
cpu_be  in  2  CPU byte enables for writes
cpu_addr  in  AW  CPU word address
cpu_din  in  DW  CPU write data
cpu_dout  out  DW  CPU read data
cpu_ack  out  1  CPU completion pulse
mem_addr  out  AW  memory address
mem_din  out  DW  memory write data
mem_be  out  2  memory byte enables
mem_rd  out  1  one-cycle read strobe
mem_we  out  1  one-cycle write strobe
mem_dout  in  DW  memory read data
grant  out  2  current owner: 0 none, 1 video, 2 DMA, 3 CPU
cpu_wait_cnt  out  16  CPU wait statistic (see Optional Feature)

Behaviour:
- Reset values: all outputs registered and 0; state IDLE; starvation counter 0.
- Reset mid-transaction:
  - Transaction is abandoned with no ack.
  - Strobes drop on the next cycle.
  - *_dout registers are cleared.
- Handshake:
  - A requester holds req, addr, we, be and din stable until it sees its ack.
  - ack is a single-cycle pulse.
  - A requester that keeps req high in the cycle after its ack is treated as issuing a new request.
- FSM IDLE:
  - Evaluates requests and picks a winner.
  - Latches the winner's addr, din, be and we.
  - Sets grant and moves to ISSUE.
  - With no request pending, stays in IDLE with grant 0.
- Priority:
  - vid_req first.
  - Then cpu_req if cpu_req is high and the starvation counter equals CPU_STARVE.
  - Then dma_req.
  - Then cpu_req.
- Starvation counter:
  - +1 on each DMA grant made while cpu_req is high.
  - Cleared on a CPU grant.
  - Cleared on a DMA grant made while cpu_req is low.
  - Saturates at CPU_STARVE.
- ISSUE (1 cycle):
  - mem_rd or mem_we high, per the latched we.
  - mem_addr, mem_din and mem_be driven from the latches.
  - mem_be = 2'b11 for video and DMA; cpu_be for the CPU; 2'b00 on reads.
  - Moves to WAIT with the latency counter at MEM_LAT.
- WAIT:
  - Counter decrements each cycle.
  - On the last cycle (counter reaches 1), a read latches mem_dout into the owner's *_dout; a write leaves *_dout unchanged.
  - Then moves to DONE.
- DONE (1 cycle):
  - Owner's ack = 1; grant keeps its value.
  - Next state is IDLE.
- Timing: request seen in IDLE at cycle t gives mem strobe at t+1 and ack at t+2+MEM_LAT. Reads and writes take the same time.
- Data retention:
  - *_dout holds its value until that requester's next read completes.
  - Video is read-only; the arbiter never writes on a video grant.
- Back-to-back grants: minimum of 3+MEM_LAT cycles per transaction.
- Request changes: requests that rise or fall while the arbiter is not in IDLE are not seen until IDLE. A request dropped before grant is never served.
- Never more than one ack high in any cycle.

Optional Feature:
- Macro ARB_WAIT_STATS_EN.
- Defined:
  - cpu_wait_cnt is a 16-bit saturating counter (stops at 16'hFFFF).
  - +1 each cycle cpu_req is high and grant != 3.
  - Cleared by reset.
- Undefined: cpu_wait_cnt is tied to 16'h0000 and no counter logic is generated.

Test Plan:
1. CPU read alone: cpu_req=1, cpu_addr=24'h000100, memory model returns 16'hA5C3 with MEM_LAT=2 → mem_rd pulses at t+1 with mem_addr=24'h000100; cpu_ack at t+4; cpu_dout=16'hA5C3; grant=3.
2. CPU byte write: cpu_we=1, cpu_be=2'b10, cpu_din=16'h1234 → one mem_we pulse with mem_be=2'b10 and mem_din=16'h1234; cpu_ack at t+4; cpu_dout unchanged.
3. Simultaneous requests: vid, dma and cpu all raised in the same cycle and held until ack → service order is video, then DMA, then CPU; acks 5 cycles apart; never two acks in one cycle.
4. Starvation: dma_req held continuously with CPU_STARVE=8 and cpu_req raised → exactly 8 DMA grants, then 1 CPU grant, then DMA resumes; counter reads 0 after the CPU grant.
5. Reset mid-operation: reset asserted during WAIT of a DMA read → no dma_ack; all outputs 0 the cycle after; next cpu_req is granted normally.
6. ARB_WAIT_STATS_EN: cpu_req held while video holds the port for 2 transactions → cpu_wait_cnt=10 at the CPU grant. Without the macro → cpu_wait_cnt stays 0.

Source files
------------

// File: rtl/vram_bus_arbiter.sv
// vram_bus_arbiter
// Shares one word-wide RAM port between video scan-out, the disk DMA engine
// and the CPU. One transaction runs at a time, IDLE -> ISSUE -> WAIT -> DONE.
// The WAIT phase lasts MEM_LAT cycles.
// Video always wins. DMA beats the CPU until CPU_STARVE consecutive DMA
// grants have been made while the CPU was waiting; the CPU is then forced.
// Build macro ARB_WAIT_STATS_EN adds the cpu_wait_cnt statistic. Without it,
// cpu_wait_cnt is tied to zero.
//
// state  | meaning
// IDLE   | arbitrate, latch the winner's request, set grant
// ISSUE  | one-cycle mem_rd / mem_we strobe
// WAIT   | count down memory latency, capture read data on the last cycle
// DONE   | one-cycle ack to the owner, grant still shown

module vram_bus_arbiter #(
  parameter int AW         = 24,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 2,
  parameter int CPU_STARVE = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [AW-1:0]     vid_addr,
  output logic [DW-1:0]     vid_dout,
  output logic              vid_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [AW-1:0]     dma_addr,
  input  logic [DW-1:0]     dma_din,
  output logic [DW-1:0]     dma_dout,
  output logic              dma_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DW/8-1:0]   cpu_be,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_din,
  output logic [DW-1:0]     cpu_dout,
  output logic              cpu_ack,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_din,
  output logic [DW/8-1:0]   mem_be,
  output logic              mem_rd,
  output logic              mem_we,
  input  logic [DW-1:0]     mem_dout,
  output logic [1:0]        grant,
  output logic [15:0]       cpu_wait_cnt
);

  localparam int BW = DW / 8;
  localparam int SW = $clog2(CPU_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(CPU_STARVE);
  localparam logic [2:0]    LAT_INIT   = 3'(MEM_LAT);

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_VID  = 2'd1;
  localparam logic [1:0] G_DMA  = 2'd2;
  localparam logic [1:0] G_CPU  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_lat_cnt;
  logic [2:0]      w_lat_nxt;
  logic [1:0]      r_grant;
  logic [1:0]      w_grant_nxt;
  logic [SW-1:0]   r_starve;
  logic [SW-1:0]   w_starve_nxt;

  logic            r_mem_rd;
  logic            r_mem_we;
  logic            w_mem_rd_nxt;
  logic            w_mem_we_nxt;
  logic            r_vid_ack;
  logic            r_dma_ack;
  logic            r_cpu_ack;
  logic            w_vid_ack_nxt;
  logic            w_dma_ack_nxt;
  logic            w_cpu_ack_nxt;
  logic            w_load;
  logic            w_capture;

  logic [1:0]      w_sel;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_din;
  logic [BW-1:0]   w_sel_be;

  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_din;
  logic [BW-1:0]   r_be;
  logic [DW-1:0]   r_vid_dout;
  logic [DW-1:0]   r_dma_dout;
  logic [DW-1:0]   r_cpu_dout;

  // Priority pick among the live requests and mux of the winner's request;
  // the byte enables are already reduced to what the memory should see.
  always_comb begin
    w_sel      = G_NONE;
    w_sel_we   = 1'b0;
    w_sel_addr = '0;
    w_sel_din  = '0;
    w_sel_be   = '0;
    if (vid_req)                                 w_sel = G_VID;
    else if (cpu_req && (r_starve == STARVE_MAX)) w_sel = G_CPU;
    else if (dma_req)                            w_sel = G_DMA;
    else if (cpu_req)                            w_sel = G_CPU;
    case (w_sel)
      G_VID: begin
        w_sel_addr = vid_addr;
      end
      G_DMA: begin
        w_sel_we   = dma_we;
        w_sel_addr = dma_addr;
        w_sel_din  = dma_din;
        w_sel_be   = dma_we ? {BW{1'b1}} : {BW{1'b0}};
      end
      G_CPU: begin
        w_sel_we   = cpu_we;
        w_sel_addr = cpu_addr;
        w_sel_din  = cpu_din;
        w_sel_be   = cpu_we ? cpu_be : {BW{1'b0}};
      end
      default: ;
    endcase
  end

  // Next-state, strobe, ack and starvation-counter logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_lat_nxt     = r_lat_cnt;
    w_grant_nxt   = r_grant;
    w_starve_nxt  = r_starve;
    w_mem_rd_nxt  = 1'b0;
    w_mem_we_nxt  = 1'b0;
    w_vid_ack_nxt = 1'b0;
    w_dma_ack_nxt = 1'b0;
    w_cpu_ack_nxt = 1'b0;
    w_load        = 1'b0;
    w_capture     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = w_sel;
        if (w_sel != G_NONE) begin
          w_state_nxt  = S_ISSUE;
          w_load       = 1'b1;
          w_mem_rd_nxt = ~w_sel_we;
          w_mem_we_nxt = w_sel_we;
          if (w_sel == G_CPU) begin
            w_starve_nxt = '0;
          end else if (w_sel == G_DMA) begin
            if (!cpu_req)                   w_starve_nxt = '0;
            else if (r_starve != STARVE_MAX) w_starve_nxt = r_starve + SW'(1);
          end
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
        w_lat_nxt   = LAT_INIT;
      end
      S_WAIT: begin
        w_lat_nxt = r_lat_cnt - 3'd1;
        if (r_lat_cnt == 3'd1) begin
          w_state_nxt   = S_DONE;
          w_capture     = 1'b1;
          w_vid_ack_nxt = (r_grant == G_VID);
          w_dma_ack_nxt = (r_grant == G_DMA);
          w_cpu_ack_nxt = (r_grant == G_CPU);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = G_NONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = G_NONE;
      end
    endcase
  end

  // Control registers: state, counters, grant, strobes and acks.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= '0;
      r_grant   <= G_NONE;
      r_starve  <= '0;
      r_mem_rd  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_vid_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_nxt;
      r_grant   <= w_grant_nxt;
      r_starve  <= w_starve_nxt;
      r_mem_rd  <= w_mem_rd_nxt;
      r_mem_we  <= w_mem_we_nxt;
      r_vid_ack <= w_vid_ack_nxt;
      r_dma_ack <= w_dma_ack_nxt;
      r_cpu_ack <= w_cpu_ack_nxt;
    end
  end

  // Request latches and per-requester read data holding registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_be       <= '0;
      r_vid_dout <= '0;
      r_dma_dout <= '0;
      r_cpu_dout <= '0;
    end else begin
      if (w_load) begin
        r_we   <= w_sel_we;
        r_addr <= w_sel_addr;
        r_din  <= w_sel_din;
        r_be   <= w_sel_be;
      end
      if (w_capture && !r_we) begin
        case (r_grant)
          G_VID:   r_vid_dout <= mem_dout;
          G_DMA:   r_dma_dout <= mem_dout;
          G_CPU:   r_cpu_dout <= mem_dout;
          default: ;
        endcase
      end
    end
  end

`ifdef ARB_WAIT_STATS_EN
  logic [15:0] r_cpu_wait_cnt;

  // Saturating count of cycles the CPU spends requesting without the port.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cpu_wait_cnt <= '0;
    end else if (cpu_req && (r_grant != G_CPU) && (r_cpu_wait_cnt != 16'hFFFF)) begin
      r_cpu_wait_cnt <= r_cpu_wait_cnt + 16'd1;
    end
  end

  assign cpu_wait_cnt = r_cpu_wait_cnt;
`else
  assign cpu_wait_cnt = 16'h0000;
`endif

  assign vid_dout = r_vid_dout;
  assign dma_dout = r_dma_dout;
  assign cpu_dout = r_cpu_dout;
  assign vid_ack  = r_vid_ack;
  assign dma_ack  = r_dma_ack;
  assign cpu_ack  = r_cpu_ack;
  assign mem_addr = r_addr;
  assign mem_din  = r_din;
  assign mem_be   = r_be;
  assign mem_rd   = r_mem_rd;
  assign mem_we   = r_mem_we;
  assign grant    = r_grant;

endmodule
